// File: rtl/ram_controller_pkg.sv
// ram_controller_pkg: shared state encoding and system-default sizes for the data RAM.
// Rev 1.0
`default_nettype none

package ram_controller_pkg;

    typedef enum logic {
        MEM_IDLE  = 1'b0,
        MEM_CLEAR = 1'b1
    } mem_state_t;

    localparam int RAM_DATA_WIDTH = 8;
    localparam int RAM_ADDR_WIDTH = 8;
    localparam int RAM_DEPTH      = 128;

endpackage

`default_nettype wire

// File: rtl/ram_controller_ram_array.sv
// ram_array: resetless single-port storage, synchronous write and registered synchronous read.
// Rev 1.0
`default_nettype none

module ram_array #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 128,
    parameter int IDX_WIDTH  = 7
) (
    input  logic                  clock,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [IDX_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[addr] <= wdata;
        end
        if (read_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_controller.sv
// ram_controller: req/ready data RAM front end with range checking and a hardware clear sequencer.
// Rev 1.0
`default_nettype none

module ram_controller
    import ram_controller_pkg::*;
#(
    parameter int DATA_WIDTH     = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH     = RAM_ADDR_WIDTH,
    parameter int DEPTH          = RAM_DEPTH,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_s2_n,
    input  logic                  req,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clear_start,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  addr_error,
    output logic                  busy
);

    localparam int                  IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if (DEPTH > 2 ** ADDR_WIDTH) begin : g_depth_check
        $error("ram_controller: DEPTH exceeds the address space of ADDR_WIDTH");
    end

    mem_state_t            state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  rd_zero;
    logic                  in_range;
    logic                  accept;
    logic                  rd_accept;
    logic                  clearing;
    logic                  ram_we;
    logic                  ram_re;
    logic [IDX_WIDTH-1:0]  ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign clearing  = (state == MEM_CLEAR);
    assign ready     = (state == MEM_IDLE) && !clear_start;
    assign in_range  = ({1'b0, address} < DEPTH_EXT);
    assign accept    = req && ready;
    assign rd_accept = accept && !write_enable;

    // The clear sequencer owns the single port for its whole run; accesses cannot be accepted then.
    assign ram_we    = clearing || (accept && write_enable && in_range);
    assign ram_re    = rd_accept && in_range;
    assign ram_addr  = clearing ? clr_addr[IDX_WIDTH-1:0] : address[IDX_WIDTH-1:0];
    assign ram_wdata = clearing ? '0 : data_in;

    ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_ram_array (
        .clock    (clock),
        .write_en (ram_we),
        .read_en  (ram_re),
        .addr     (ram_addr),
        .wdata    (ram_wdata),
        .rdata    (ram_rdata)
    );

    // The array read register is resetless, so reset and out-of-range reads force zero through this flag.
    assign data_out = rd_zero ? '0 : ram_rdata;

    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            state      <= CLEAR_ON_RESET ? MEM_CLEAR : MEM_IDLE;
            busy       <= CLEAR_ON_RESET;
            clr_addr   <= '0;
            data_valid <= 1'b0;
            addr_error <= 1'b0;
            rd_zero    <= 1'b1;
        end else begin
            data_valid <= rd_accept;
            addr_error <= accept && !in_range;
            if (rd_accept) begin
                rd_zero <= !in_range;
            end
            case (state)
                MEM_IDLE: begin
                    if (clear_start) begin
                        state    <= MEM_CLEAR;
                        busy     <= 1'b1;
                        clr_addr <= '0;
                    end
                end
                MEM_CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state    <= MEM_IDLE;
                        busy     <= 1'b0;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_controller.sv
// tb_ram_controller: directed stimulus with a queue scoreboard checked by a separate monitor.
// Rev 1.0
`default_nettype none

module tb_ram_controller;

    typedef struct {
        int         n;
        logic       dv;
        logic [7:0] d;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         ncnt = 0;
    exp_t       qa[$];
    exp_t       qb[$];

    // instance A: defaults
    logic       rst_a_n, req_a, we_a, clr_a;
    logic [7:0] addr_a, din_a;
    logic       ready_a, dv_a, ae_a, busy_a;
    logic [7:0] dout_a;
    // instance B: small array, no clear on reset
    logic       rst_b_n, req_b, we_b, clr_b;
    logic [3:0] addr_b;
    logic [7:0] din_b;
    logic       ready_b, dv_b, ae_b, busy_b;
    logic [7:0] dout_b;

    always #5 clk = ~clk;

    ram_controller u_dut_a (
        .clock        (clk),
        .reset_s2_n   (rst_a_n),
        .req          (req_a),
        .write_enable (we_a),
        .address      (addr_a),
        .data_in      (din_a),
        .clear_start  (clr_a),
        .ready        (ready_a),
        .data_out     (dout_a),
        .data_valid   (dv_a),
        .addr_error   (ae_a),
        .busy         (busy_a)
    );

    ram_controller #(
        .DATA_WIDTH     (8),
        .ADDR_WIDTH     (4),
        .DEPTH          (16),
        .CLEAR_ON_RESET (1'b0)
    ) u_dut_b (
        .clock        (clk),
        .reset_s2_n   (rst_b_n),
        .req          (req_b),
        .write_enable (we_b),
        .address      (addr_b),
        .data_in      (din_b),
        .clear_start  (clr_b),
        .ready        (ready_b),
        .data_out     (dout_b),
        .data_valid   (dv_b),
        .addr_error   (ae_b),
        .busy         (busy_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
        end
    endtask

    // Monitor: outputs are expected on the negedge after the accepting posedge.
    always @(negedge clk) begin
        exp_t e;
        ncnt++;
        if (dv_a || ae_a) begin
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL A_unexpected dv=%0b err=%0b data=%h at n=%0d", dv_a, ae_a, dout_a, ncnt);
            end else begin
                e = qa.pop_front();
                if (dv_a !== e.dv || ae_a !== e.err || (e.dv && dout_a !== e.d) || ncnt != e.n) begin
                    bad++;
                    $display("FAIL A_resp actual dv=%0b err=%0b data=%h n=%0d expected dv=%0b err=%0b data=%h n=%0d",
                             dv_a, ae_a, dout_a, ncnt, e.dv, e.err, e.d, e.n);
                end
            end
        end else if (qa.size() > 0 && qa[0].n <= ncnt) begin
            total++;
            bad++;
            $display("FAIL A_missing actual=no_output expected dv=%0b err=%0b data=%h at n=%0d",
                     qa[0].dv, qa[0].err, qa[0].d, qa[0].n);
            void'(qa.pop_front());
        end
        if (dv_b || ae_b) begin
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL B_unexpected dv=%0b err=%0b data=%h at n=%0d", dv_b, ae_b, dout_b, ncnt);
            end else begin
                e = qb.pop_front();
                if (dv_b !== e.dv || ae_b !== e.err || (e.dv && dout_b !== e.d) || ncnt != e.n) begin
                    bad++;
                    $display("FAIL B_resp actual dv=%0b err=%0b data=%h n=%0d expected dv=%0b err=%0b data=%h n=%0d",
                             dv_b, ae_b, dout_b, ncnt, e.dv, e.err, e.d, e.n);
                end
            end
        end else if (qb.size() > 0 && qb[0].n <= ncnt) begin
            total++;
            bad++;
            $display("FAIL B_missing actual=no_output expected data=%h at n=%0d", qb[0].d, qb[0].n);
            void'(qb.pop_front());
        end
    end

    task automatic a_drive(input logic r, input logic w, input logic [7:0] ad, input logic [7:0] d,
                           input logic c);
        @(posedge clk);
        #1;
        req_a = r; we_a = w; addr_a = ad; din_a = d; clr_a = c;
    endtask

    task automatic a_write(input logic [7:0] ad, input logic [7:0] d);
        a_drive(1'b1, 1'b1, ad, d, 1'b0);
        if (ad >= 8'd128) qa.push_back('{ncnt + 2, 1'b0, 8'h00, 1'b1});
    endtask

    task automatic a_read(input logic [7:0] ad, input logic [7:0] expd);
        a_drive(1'b1, 1'b0, ad, 8'h00, 1'b0);
        if (ad >= 8'd128) qa.push_back('{ncnt + 2, 1'b1, 8'h00, 1'b1});
        else              qa.push_back('{ncnt + 2, 1'b1, expd, 1'b0});
    endtask

    task automatic a_idle();
        a_drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic b_drive(input logic r, input logic w, input logic [3:0] ad, input logic [7:0] d);
        @(posedge clk);
        #1;
        req_b = r; we_b = w; addr_b = ad; din_b = d; clr_b = 1'b0;
    endtask

    // Counts negedges with busy high; optionally pulses clear_start once at count pulse_at.
    task automatic count_busy_a(input int pulse_at, output int cnt);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            clr_a = (cnt == pulse_at);
            if (busy_a) cnt++;
            else break;
        end
        clr_a = 1'b0;
    endtask

    initial begin
        int cnt;
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        req_a = 0; we_a = 0; addr_a = 0; din_a = 0; clr_a = 0;
        req_b = 0; we_b = 0; addr_b = 0; din_b = 0; clr_b = 0;
        #1;
        rst_a_n = 1'b0; rst_b_n = 1'b0;

        @(negedge clk);
        check("rst_data_out", dout_a, 8'h00);
        check("rst_data_valid", dv_a, 1'b0);
        check("rst_addr_error", ae_a, 1'b0);
        check("rst_busy", busy_a, 1'b1);
        check("rst_ready", ready_a, 1'b0);
        check("rst_b_busy", busy_b, 1'b0);
        check("rst_b_ready", ready_b, 1'b1);

        @(posedge clk);
        #1;
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        count_busy_a(-1, cnt);
        check("init_clear_cycles", cnt, 128);
        check("ready_after_clear", ready_a, 1'b1);

        a_read(8'h05, 8'h00);
        a_write(8'h10, 8'hA5);
        a_read(8'h10, 8'hA5);
        a_write(8'h80, 8'h3C);
        a_read(8'h80, 8'h00);
        a_read(8'h00, 8'h00);
        a_write(8'h7F, 8'hC3);
        a_read(8'h7F, 8'hC3);
        a_write(8'h11, 8'h5A);
        a_read(8'h11, 8'h5A);
        a_read(8'hFF, 8'h00);
        a_idle();

        // clear_start together with a write: the write is dropped
        a_drive(1'b1, 1'b1, 8'h20, 8'hFF, 1'b1);
        #1;
        check("ready_low_on_clear_start", ready_a, 1'b0);
        a_idle();
        count_busy_a(50, cnt);
        check("clear_cycles_with_restart_attempt", cnt, 128);
        a_read(8'h10, 8'h00);
        a_read(8'h20, 8'h00);
        a_read(8'h7F, 8'h00);

        // reset in the middle of a clear
        a_write(8'h11, 8'h5A);
        a_read(8'h11, 8'h5A);
        a_drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        a_idle();
        repeat (64) @(posedge clk);
        #2;
        check("hold_data_out_in_clear", dout_a, 8'h5A);
        check("busy_mid_clear", busy_a, 1'b1);
        rst_a_n = 1'b0;
        #1;
        check("midclr_rst_data_out", dout_a, 8'h00);
        check("midclr_rst_data_valid", dv_a, 1'b0);
        check("midclr_rst_busy", busy_a, 1'b1);
        check("midclr_rst_ready", ready_a, 1'b0);
        @(posedge clk);
        #1;
        rst_a_n = 1'b1;
        count_busy_a(-1, cnt);
        check("clear_cycles_after_midclr_rst", cnt, 128);
        a_read(8'h11, 8'h00);
        a_idle();

        // instance B: no clear on reset, 16 writes then 16 back-to-back reads
        @(negedge clk);
        check("b_ready_after_rst", ready_b, 1'b1);
        check("b_busy_after_rst", busy_b, 1'b0);
        for (int i = 0; i < 16; i++) b_drive(1'b1, 1'b1, 4'(i), 8'hC0 + 8'(i));
        for (int i = 0; i < 16; i++) begin
            b_drive(1'b1, 1'b0, 4'(i), 8'h00);
            qb.push_back('{ncnt + 2, 1'b1, 8'hC0 + 8'(i), 1'b0});
        end
        b_drive(1'b0, 1'b0, 4'h0, 8'h00);

        repeat (5) @(negedge clk);
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
